// File: rtl/nibble_serial_add_ctrl.sv
// Serial adder that uses one 4-bit ripple slice, LSB nibble first, with a valid/ready handshake on both sides.
// Optional subtract mode: define NIBBLE_SERIAL_ADD_SUB_EN to add the 'sub' input port.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic             r_carry, r_cout, r_ovf;
    logic [CW-1:0]    r_cnt;
    logic             w_accept, w_last;
    logic [3:0]       w_an, w_bn;
    logic [4:0]       w_slice;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    assign w_accept = start_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == CW'(NIB - 1));

`ifdef NIBBLE_SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1; cin is ignored in that mode.
    assign w_b_load = sub ? ~in_b : in_b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = in_b;
    assign w_c_load = cin;
`endif

    assign w_an    = r_a[r_cnt*4 +: 4];
    assign w_bn    = r_b[r_cnt*4 +: 4];
    assign w_slice = {1'b0, w_an} + {1'b0, w_bn} + {4'b0, r_carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        start_ready = 1'b0;
        busy        = 1'b0;
        res_valid   = 1'b0;
        case (r_state)
            S_IDLE:  start_ready = 1'b1;
            S_RUN:   busy        = 1'b1;
            S_DONE:  res_valid   = 1'b1;
            default: start_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_sum[r_cnt*4 +: 4] <= w_slice[3:0];
            r_carry             <= w_slice[4];
            r_cnt               <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_slice[4];
                // Carry into the MSB is recovered from the sum bit: c3 = a3 ^ b3 ^ s3.
                r_ovf  <= w_an[3] ^ w_bn[3] ^ w_slice[3] ^ w_slice[4];
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed + random bench for nibble_serial_add_ctrl (WIDTH=16) against an arithmetic reference model.
module tb_nibble_serial_add_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic             cin;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] sum;
    logic             cout, ovf, busy;

    int checks = 0;
    int errors = 0;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .in_a(in_a), .in_b(in_b), .cin(cin),
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
        .sub(sub),
`endif
        .res_valid(res_valid), .res_ready(res_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                         output logic [15:0] e_sum, output logic e_cout, output logic e_ovf);
        int ua, ub, sa, sb, tot, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            tot    = ua - ub;
            e_sum  = tot[15:0];
            e_cout = (ua >= ub);
            sr     = sa - sb;
        end else begin
            tot    = ua + ub + int'(c);
            e_sum  = tot[15:0];
            e_cout = tot[16];
            sr     = sa + sb + int'(c);
        end
        e_ovf = (sr > 32767) || (sr < -32768);
    endtask

    // Runs one transaction; accept happens on the next rising edge after the call.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                         input int hold, input bit junk);
        logic [15:0] e_sum;
        logic        e_cout, e_ovf;
        model(a, b, c, s, e_sum, e_cout, e_ovf);
        start_valid = 1'b1;
        in_a = a; in_b = b; cin = c;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
        sub = s;
`endif
        res_ready = (hold == 0);
        #1 chk("start_ready_idle", 32'(start_ready), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= NIB; k++) begin
            #1;
            if (junk) begin
                in_a = 16'($urandom); in_b = 16'($urandom); cin = 1'($urandom);
                chk("start_ready_run", 32'(start_ready), 32'd0);
            end else if (k == 1) begin
                start_valid = 1'b0;
                in_a = 16'($urandom); in_b = 16'($urandom);
            end
            if (k == 1) chk("busy_run", 32'(busy), 32'd1);
            @(posedge clk);
        end
        #1;
        chk("res_valid_latency", 32'(res_valid), 32'd1);
        chk("sum", 32'(sum), 32'(e_sum));
        chk("cout", 32'(cout), 32'(e_cout));
        chk("ovf", 32'(ovf), 32'(e_ovf));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("res_valid_hold", 32'(res_valid), 32'd1);
            chk("sum_hold", 32'(sum), 32'(e_sum));
            chk("cout_hold", 32'(cout), 32'(e_cout));
            if (junk) chk("start_ready_done", 32'(start_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("res_valid_after_hs", 32'(res_valid), 32'd0);
        chk("start_ready_after_hs", 32'(start_ready), 32'd1);
        start_valid = 1'b0;
        res_ready   = 1'b0;
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rc, rs;
        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
        in_a = '0; in_b = '0; cin = 1'b0;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        #2;
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        #10 rst_n = 1'b1;

        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 3, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1, 1'b1);
        do_op(16'hABCD, 16'h1111, 1'b1, 1'b0, 2, 1'b1);
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1, 1'b0);
`endif

        // Reset in the middle of a run: after nibbles 0..2 have been stored.
        start_valid = 1'b1; in_a = 16'h9999; in_b = 16'h7777; cin = 1'b1;
        @(posedge clk); #1 start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_start_ready", 32'(start_ready), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", 32'(res_valid), 32'd0);
            chk("post_rst_sum_zero", 32'(sum), 32'd0);
        end

        // Request accepted on the first rising edge after release.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        do_op(16'h00F0, 16'h0F0F, 1'b0, 1'b0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand width in bits; legal values are multiples of 4, minimum 4; NIB = WIDTH/4.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start_valid  input  1  request to start an addition.
REQ-005 SHALL have port: start_ready  output  1  block can accept a request.
REQ-006 SHALL have ports: in_a and in_b, each input, WIDTH bits, operands.
REQ-007 SHALL have port: cin  input  1  initial carry-in.
REQ-008 SHALL have port: res_valid  output  1  result available.
REQ-009 SHALL have port: res_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port: sum  output  WIDTH  result word.
REQ-011 SHALL have port: cout  output  1  final carry-out.
REQ-012 SHALL have port: ovf  output  1  signed overflow of the WIDTH-bit result.
REQ-013 SHALL have port: busy  output  1  high in RUN state.

Function
REQ-014 SHALL compute in_a+in_b+cin serially, using exactly one 4-bit ripple-carry adder slice, nibble 0 (LSB) first.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on accept, RUN->DONE after nibble NIB-1, DONE->IDLE on res_valid&&res_ready.
REQ-016 SHALL drive start_ready=1 only in IDLE; accept = start_valid&&start_ready at a rising edge.
REQ-017 SHALL capture in_a, in_b and cin only at accept; later input changes SHALL not affect the result.
REQ-018 SHALL, in RUN, use a nibble counter 0..NIB-1; each edge stores one sum nibble and registers the slice carry-out as the next carry-in.
REQ-019 SHALL assert res_valid exactly NIB edges after the accept edge (WIDTH=16: 4 cycles).
REQ-020 SHALL hold sum, cout and ovf stable while res_valid=1 and res_ready=0.
REQ-021 SHALL set ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-022 SHALL ignore start_valid in RUN and DONE; no request is queued.
REQ-023 SHALL, on a DONE handshake, return to IDLE; start_ready SHALL rise on the following cycle, so back-to-back same-cycle restart is not supported.
REQ-024 SHALL, with res_ready held high, complete DONE in one cycle.
REQ-025 SHALL reject WIDTH not a multiple of 4 or below 4 with an elaboration-time error.

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE, counter 0, carry 0, sum 0, cout 0, ovf 0, res_valid 0, busy 0, start_ready 1.
REQ-027 SHALL abort any operation in progress on reset assertion; no partial result SHALL appear after release.
REQ-028 SHALL accept a request on the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with NIBBLE_SERIAL_ADD_SUB_EN defined, add input port sub (1 bit), captured at accept; sub=1 computes in_a-in_b as in_a+~in_b+1, ignoring cin.
REQ-030 SHALL, without NIBBLE_SERIAL_ADD_SUB_EN, have no sub port and perform addition only.

Verification
REQ-031 SHALL cover: in_a=0xFFFF, in_b=0x0001, cin=0 -> 4 cycles later res_valid=1, sum=0x0000, cout=1, ovf=0.
REQ-032 SHALL cover: in_a=0x7FFF, in_b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-033 SHALL cover: 0x1234+0x4321, cin=1 with res_ready low 3 cycles -> sum=0x5556 held stable; DONE->IDLE on the cycle res_ready rises.
REQ-034 SHALL cover: start_valid high with new operands throughout RUN -> ignored; start_ready=0 until after the DONE handshake.
REQ-035 SHALL cover: rst_n pulsed low after nibble 2 -> all outputs at reset values, start_ready=1, no res_valid after release.
REQ-036 SHALL cover, with NIBBLE_SERIAL_ADD_SUB_EN defined: in_a=0x0005, in_b=0x0007, sub=1 -> sum=0xFFFE, cout=0.
